fc_ip_engine: RTL and testbench
===============================

# fc_ip_engine

Parametrised multi-lane inner-product engine for the fully-connected stage: accumulates one input vector against LANES weight columns in parallel, adds per-lane bias, applies optional ReLU, and exports saturated results lane by lane. Sits between the conv-buffer/DDR fetch path (input and weight streams) and the FC output buffer. It generalises the fixed 16-bit FC datapath to configurable lane count, accumulator width and run-time layer length.

## Interface
- FW, 16, data/weight/bias/output width, signed two's complement, Q(FW-FRAC).FRAC
- FRAC, 8, fraction bits of all FW-wide values
- LANES, 8, output neurons computed in parallel (≥2)
- LEN_W, 16, width of layer-length configuration
- AW, 48, accumulator width; must be ≥ 2*FW+LEN_W
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  start pulse; sampled only in IDLE
- cfg_len_i  input  LEN_W  input-vector length, latched at start
- cfg_relu_i  input  1  ReLU enable, latched at start
- bias_i  input  LANES*FW  per-lane bias, lane i at [i*FW +: FW], latched at start
- data_i  input  FW  input element
- weight_i  input  LANES*FW  weights for current element, lane i at [i*FW +: FW]
- data_valid_i  input  1  data_i/weight_i valid
- data_ready_o  output  1  engine accepts a beat
- out_data_o  output  FW  result of lane out_lane_o
- out_lane_o  output  $clog2(LANES)  lane index of out_data_o
- out_valid_o  output  1  output valid
- out_ready_i  input  1  downstream accepts output
- out_last_o  output  1  marks lane LANES-1
- busy_o  output  1  high in any state except IDLE
- done_o  output  1  one-cycle pulse after last output handshake

## Operation
- States IDLE, ACCUM, FLUSH, DRAIN.
- IDLE: start_i=1 latches cfg and bias; acc[i] <= sign-extend(bias[i]) << FRAC; beat counter cleared; next state ACCUM if cfg_len_i≠0, else FLUSH.
- ACCUM: data_ready_o=1 while count<len; beat accepted when data_valid_i & data_ready_o; prod[i] <= data_i*weight_i[i] (full 2*FW signed) registered; next cycle acc[i] <= acc[i] + sign-extend(prod[i]). On accepting beat number len, next state FLUSH.
- FLUSH: one cycle; last product added to acc; next state DRAIN, lane pointer 0.
- DRAIN: out_data_o = sat(relu(acc[lane] >>> FRAC)); arithmetic shift (truncate toward -inf); ReLU maps negative to 0 when cfg_relu latched 1; saturate to [-2^(FW-1), 2^(FW-1)-1]. Lane advances on out_valid_o & out_ready_i; after lane LANES-1 handshake, next state IDLE, done_o=1 for one cycle.
- Accumulator wraps modulo 2^AW (no saturation internally).
- start_i outside IDLE ignored; data_valid_i outside ACCUM ignored.
- rst_i at any time: all state, counters, accumulators and outputs cleared immediately; in-flight job discarded.

## Timing
- Reset values: data_ready_o 0, out_data_o 0, out_lane_o 0, out_valid_o 0, out_last_o 0, busy_o 0, done_o 0.
- start_i at edge N: busy_o=1 and (len>0) data_ready_o=1 from N+1.
- data_ready_o drops the cycle after the len-th accepted beat; gaps in data_valid_i stall without loss.
- Last beat accepted at edge t: FLUSH at t+1, out_valid_o=1 lane 0 at t+2. len=0: out_valid_o at N+2.
- out_data_o, out_lane_o, out_last_o stable while out_valid_o & !out_ready_i.
- With out_ready_i held 1, one lane per cycle; done_o at edge after last handshake, busy_o falls same cycle; start_i accepted the cycle done_o is high.
- Minimum job: len+LANES+2 cycles from start to done_o.

## Test plan
- LANES=8, len=4, data 0x0100, weight lane i = i*0x0100, bias 0, relu 0 -> outputs 0x0000,0x0400,…,0x1C00 lanes 0–7, out_last_o on lane 7, single done_o.
- len=0, bias lane0=0xFF00 others 0x0080 -> relu 0: 0xFF00, 0x0080…; relu 1: 0x0000, 0x0080….
- len=4, data 0x7FFF, weight 0x7FFF -> 0x7FFF all lanes; weight 0x8001 -> 0x8000 all lanes (saturation both signs).
- Random data_valid_i gaps plus out_ready_i low 5 cycles at lane 3 -> results match golden model, outputs held stable, lanes strictly ordered, start_i pulses during busy ignored.
- rst_i asserted mid-ACCUM (beat 2 of 10) -> all outputs 0 next cycle; fresh start len=4 gives same results as first test.
- len=65535 (max), data 0x0100, weight 0x0100 -> accumulator no wrap, outputs saturate 0x7FFF; out_valid_o exactly 2 cycles after last beat.

Source files
------------

// File: rtl/fc_ip_engine.sv
// Multi-lane FC inner-product engine: bias-preloaded accumulators, one registered
// product stage, optional ReLU and saturation, lane-serial result export.
module fc_ip_engine #(
   parameter int FW    = 16,
   parameter int FRAC  = 8,
   parameter int LANES = 8,
   parameter int LEN_W = 16,
   parameter int AW    = 48
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [LEN_W-1:0]           cfg_len_i,
   input  logic                       cfg_relu_i,
   input  logic [LANES*FW-1:0]        bias_i,
   input  logic [FW-1:0]              data_i,
   input  logic [LANES*FW-1:0]        weight_i,
   input  logic                       data_valid_i,
   output logic                       data_ready_o,
   output logic [FW-1:0]              out_data_o,
   output logic [$clog2(LANES)-1:0]   out_lane_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic                       out_last_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int LW = $clog2(LANES);
   localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (FW-1)) - 64'sd1);
   localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);
   localparam logic [FW-1:0] OUT_MAX = {1'b0, {(FW-1){1'b1}}};
   localparam logic [FW-1:0] OUT_MIN = {1'b1, {(FW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DRAIN} state_t;

   state_t                   state_q, state_d;
   logic [LEN_W-1:0]         len_q, len_d;
   logic [LEN_W-1:0]         cnt_q, cnt_d;
   logic                     relu_q, relu_d;
   logic [LW-1:0]            lane_q, lane_d;
   logic                     done_q, done_d;
   logic                     prod_vld_q, prod_vld_d;
   logic signed [AW-1:0]     acc_q [LANES];
   logic signed [AW-1:0]     acc_d [LANES];
   logic signed [2*FW-1:0]   prod_q [LANES];
   logic signed [2*FW-1:0]   prod_d [LANES];

   logic signed [FW-1:0]     bias_l [LANES];
   logic signed [FW-1:0]     wgt_l [LANES];
   logic signed [FW-1:0]     data_s;
   logic                     beat, out_hs, last_lane, start_ok;
   logic signed [AW-1:0]     sel_acc, shifted;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign bias_l[g] = bias_i[g*FW +: FW];
      assign wgt_l[g]  = weight_i[g*FW +: FW];
   end

   assign data_s    = data_i;
   assign start_ok  = (state_q == S_IDLE) && start_i;
   assign beat      = data_valid_i && data_ready_o;
   assign out_hs    = out_valid_o && out_ready_i;
   assign last_lane = (lane_q == LW'(LANES-1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = (cfg_len_i != '0) ? S_ACCUM : S_FLUSH;
         S_ACCUM: if (beat && (cnt_q + LEN_W'(1)) == len_q) state_d = S_FLUSH;
         S_FLUSH: state_d = S_DRAIN;
         S_DRAIN: if (out_hs && last_lane) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      len_d      = len_q;
      cnt_d      = cnt_q;
      relu_d     = relu_q;
      lane_d     = lane_q;
      done_d     = 1'b0;
      prod_vld_d = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         acc_d[i]  = acc_q[i];
         prod_d[i] = prod_q[i];
      end

      if (start_ok) begin
         len_d  = cfg_len_i;
         relu_d = cfg_relu_i;
         cnt_d  = '0;
         lane_d = '0;
         for (int i = 0; i < LANES; i++) acc_d[i] = AW'(bias_l[i]) <<< FRAC;
      end

      // the product registered on the previous beat lands one cycle later, including in FLUSH
      if (prod_vld_q && (state_q == S_ACCUM || state_q == S_FLUSH)) begin
         for (int i = 0; i < LANES; i++) acc_d[i] = acc_q[i] + AW'(prod_q[i]);
      end

      if (beat) begin
         cnt_d      = cnt_q + LEN_W'(1);
         prod_vld_d = 1'b1;
         for (int i = 0; i < LANES; i++)
            prod_d[i] = (2*FW)'(data_s) * (2*FW)'(wgt_l[i]);
      end

      if (state_q == S_FLUSH) lane_d = '0;

      if (out_hs) begin
         if (last_lane) begin
            lane_d = '0;
            done_d = 1'b1;
         end else begin
            lane_d = lane_q + LW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         len_q      <= '0;
         cnt_q      <= '0;
         relu_q     <= 1'b0;
         lane_q     <= '0;
         done_q     <= 1'b0;
         prod_vld_q <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            acc_q[i]  <= '0;
            prod_q[i] <= '0;
         end
      end else begin
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         relu_q     <= relu_d;
         lane_q     <= lane_d;
         done_q     <= done_d;
         prod_vld_q <= prod_vld_d;
         for (int i = 0; i < LANES; i++) begin
            acc_q[i]  <= acc_d[i];
            prod_q[i] <= prod_d[i];
         end
      end
   end

   always_comb begin
      sel_acc      = acc_q[lane_q];
      shifted      = sel_acc >>> FRAC;
      data_ready_o = (state_q == S_ACCUM) && (cnt_q < len_q);
      out_valid_o  = (state_q == S_DRAIN);
      out_lane_o   = lane_q;
      out_last_o   = out_valid_o && last_lane;
      busy_o       = (state_q != S_IDLE);
      done_o       = done_q;
      out_data_o   = '0;
      if (out_valid_o) begin
         if (relu_q && shifted < 0)  out_data_o = '0;
         else if (shifted > SAT_MAX) out_data_o = OUT_MAX;
         else if (shifted < SAT_MIN) out_data_o = OUT_MIN;
         else                        out_data_o = shifted[FW-1:0];
      end
   end

endmodule

// File: tb/tb_fc_ip_engine.sv
// Randomized scoreboard bench for fc_ip_engine: an integer reference model fills
// an expected-result queue, and a monitor pops it on every output handshake.
module tb_fc_ip_engine;

   localparam int FW = 16, FRAC = 8, LANES = 8, LEN_W = 16, AW = 48;

   logic                  clk_i = 1'b0;
   logic                  rst_i = 1'b1;
   logic                  start_i = 1'b0;
   logic [LEN_W-1:0]      cfg_len_i = '0;
   logic                  cfg_relu_i = 1'b0;
   logic [LANES*FW-1:0]   bias_i = '0;
   logic [FW-1:0]         data_i = '0;
   logic [LANES*FW-1:0]   weight_i = '0;
   logic                  data_valid_i = 1'b0;
   logic                  data_ready_o;
   logic [FW-1:0]         out_data_o;
   logic [2:0]            out_lane_o;
   logic                  out_valid_o;
   logic                  out_ready_i = 1'b0;
   logic                  out_last_o;
   logic                  busy_o;
   logic                  done_o;

   fc_ip_engine #(.FW(FW), .FRAC(FRAC), .LANES(LANES), .LEN_W(LEN_W), .AW(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cfg_len_i(cfg_len_i),
      .cfg_relu_i(cfg_relu_i), .bias_i(bias_i), .data_i(data_i), .weight_i(weight_i),
      .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .out_data_o(out_data_o),
      .out_lane_o(out_lane_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          lane;
      logic [15:0] data;
      bit          last;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0, bad = 0;
   int          cyc = 0;
   int          ready_mode = 0;
   int          stall_cnt = 0;
   logic [15:0] j_bias [LANES];
   logic [15:0] f_data;
   logic [15:0] f_w [LANES];

   always @(posedge clk_i) cyc++;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_out(input longint a, input bit relu);
      longint v;
      a = (a <<< (64 - AW)) >>> (64 - AW);
      v = a >>> FRAC;
      if (relu && v < 0) v = 0;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return v[15:0];
   endfunction

   // Monitor: decides out_ready_i for the coming edge and checks the beat it will accept.
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data;
   logic [2:0]  prev_lane;
   logic        prev_last;
   always @(negedge clk_i) begin
      bit   r;
      exp_t e;
      if (rst_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", out_valid_o, 1);
            chk("hold_data", out_data_o, prev_data);
            chk("hold_lane", out_lane_o, prev_lane);
            chk("hold_last", out_last_o, prev_last);
         end
         case (ready_mode)
            0: r = 1'b1;
            1: r = ($urandom_range(0, 99) < 70);
            default: begin
               if (out_valid_o && out_lane_o == 3'd3 && stall_cnt < 5) begin
                  r = 1'b0;
                  stall_cnt++;
               end else r = 1'b1;
            end
         endcase
         out_ready_i = r;
         if (out_valid_o && r) begin
            if (sbq.size() == 0) begin
               chk("sb_underflow_lane", out_lane_o, 0);
               bad++;
               total++;
               $display("FAIL unexpected_output: lane %0d data %0h with empty scoreboard", out_lane_o, out_data_o);
            end else begin
               e = sbq.pop_front();
               chk("out_lane", out_lane_o, e.lane);
               chk("out_data", out_data_o, e.data);
               chk("out_last", out_last_o, e.last);
            end
         end
         prev_stall = out_valid_o && !r;
         prev_data  = out_data_o;
         prev_lane  = out_lane_o;
         prev_last  = out_last_o;
      end
   end

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_ready"}, data_ready_o, 0);
      chk({tag, "_data"}, out_data_o, 0);
      chk({tag, "_lane"}, out_lane_o, 0);
      chk({tag, "_valid"}, out_valid_o, 0);
      chk({tag, "_last"}, out_last_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
   endtask

   task automatic run_job(input int len, input bit relu, input bit rnd_data, input int gap_pct,
                          input bit spam, input int rmode, input bit chk_min);
      longint      acc [LANES];
      logic [15:0] d;
      logic [15:0] w [LANES];
      bit          v, rdy, got;
      int          n, guard, s_cyc;
      exp_t        e;
      ready_mode = rmode;
      stall_cnt  = 0;
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
      cfg_len_i  = len[15:0];
      cfg_relu_i = relu;
      for (int i = 0; i < LANES; i++) begin
         bias_i[i*FW +: FW] = j_bias[i];
         acc[i] = longint'($signed(j_bias[i])) * 256;
      end
      start_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      s_cyc = cyc;
      chk("start_busy", busy_o, 1);
      chk("start_ready", data_ready_o, (len > 0));
      n = 0;
      guard = 0;
      while (n < len && guard < 4*len + 100) begin
         v = ($urandom_range(0, 99) >= gap_pct);
         d = rnd_data ? 16'($urandom) : f_data;
         for (int i = 0; i < LANES; i++) begin
            w[i] = rnd_data ? 16'($urandom) : f_w[i];
            weight_i[i*FW +: FW] = w[i];
         end
         data_i = d;
         data_valid_i = v;
         if (spam) start_i = 1'($urandom_range(0, 1));
         rdy = data_ready_o;
         @(posedge clk_i);
         if (v && rdy) begin
            for (int i = 0; i < LANES; i++)
               acc[i] += longint'($signed(d)) * longint'($signed(w[i]));
            n++;
         end
         @(negedge clk_i);
         guard++;
      end
      data_valid_i = 1'b0;
      start_i = 1'b0;
      chk("beats_accepted", n, len);
      chk("ready_after_last", data_ready_o, 0);
      chk("valid_early", out_valid_o, 0);
      for (int i = 0; i < LANES; i++) begin
         e.lane = i;
         e.data = model_out(acc[i], relu);
         e.last = (i == LANES-1);
         sbq.push_back(e);
      end
      @(negedge clk_i);
      chk("valid_latency", out_valid_o, 1);
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (done_o) begin
            got = 1'b1;
            break;
         end
         start_i = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk_i);
      end
      start_i = 1'b0;
      chk("done_seen", got, 1);
      chk("busy_at_done", busy_o, 0);
      if (chk_min) chk("min_job_cycles", cyc + 1 - s_cyc, len + LANES + 2);
      chk("sb_empty", sbq.size(), 0);
      @(negedge clk_i);
      chk("done_single", done_o, 0);
      chk("idle_after", busy_o, 0);
   endtask

   task automatic setup_test1();
      f_data = 16'h0100;
      for (int i = 0; i < LANES; i++) begin
         j_bias[i] = 16'h0000;
         f_w[i] = 16'(i * 256);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk_i);
      chk_zero_outputs("reset");
      rst_i = 1'b0;
      @(negedge clk_i);

      setup_test1();
      run_job(4, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

      j_bias[0] = 16'hFF00;
      for (int i = 1; i < LANES; i++) j_bias[i] = 16'h0080;
      run_job(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
      run_job(0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

      for (int i = 0; i < LANES; i++) begin
         j_bias[i] = 16'h0000;
         f_w[i] = 16'h7FFF;
      end
      f_data = 16'h7FFF;
      run_job(4, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      for (int i = 0; i < LANES; i++) f_w[i] = 16'h8001;
      run_job(4, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < LANES; i++) j_bias[i] = 16'($urandom);
         run_job($urandom_range(1, 24), 1'($urandom_range(0, 1)), 1'b1, 30, 1'b1, 1, 1'b0);
      end
      for (int i = 0; i < LANES; i++) j_bias[i] = 16'($urandom);
      run_job(12, 1'b1, 1'b1, 40, 1'b1, 2, 1'b0);
      chk("lane3_stall_cycles", stall_cnt, 5);

      // abort a len=10 job after two beats
      setup_test1();
      ready_mode = 0;
      @(negedge clk_i);
      cfg_len_i = 16'd10;
      cfg_relu_i = 1'b0;
      bias_i = '0;
      start_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      data_i = 16'h0100;
      for (int i = 0; i < LANES; i++) weight_i[i*FW +: FW] = 16'h0300;
      data_valid_i = 1'b1;
      repeat (2) begin
         @(posedge clk_i);
         @(negedge clk_i);
      end
      chk("pre_reset_busy", busy_o, 1);
      rst_i = 1'b1;
      #1;
      chk_zero_outputs("midrst");
      @(negedge clk_i);
      chk_zero_outputs("midrst_cyc");
      data_valid_i = 1'b0;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_reset_idle", busy_o, 0);
      run_job(4, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

      f_data = 16'h0100;
      for (int i = 0; i < LANES; i++) begin
         j_bias[i] = 16'h0000;
         f_w[i] = 16'h0100;
      end
      run_job(65535, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
